// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory interface: FSM encoding,
// byte-lane count and the request address check.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned BYTE_LANES = 4;

  // Misaligned byte address, or any bit set above the implemented word range.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port byte-enabled RAM with registered read; contents survive reset.
module dmem_array
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Read returns the pre-write contents when a write hits the same word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the multi-cycle CPU: one request at a time,
// WAIT_CYCLES wait states, then a byte-enabled write or a word read.
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BYTE_LANES-1:0] req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic                  err_q, err_d;
  logic                  rsel_q, rsel_d;

  logic                  enter_resp;
  logic                  cur_wr, cur_err;
  logic [31:0]           cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [BYTE_LANES-1:0] cur_be;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    err_d      = err_q;
    rsel_d     = rsel_q;
    enter_resp = 1'b0;

    // With zero wait states the access happens on the accept edge itself,
    // so the live request feeds the RAM while idle.
    cur_wr    = (state_q == ST_IDLE) ? req_write : wr_q;
    cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    cur_be    = (state_q == ST_IDLE) ? req_be    : be_q;
    cur_err   = addr_err(cur_addr, ADDR_WIDTH);

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_INIT;
          if (WAIT_CYCLES == 0) enter_resp = 1'b1;
          else                  state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) enter_resp = 1'b1;
        else             cnt_d      = cnt_q - 1'b1;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
          rsel_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      state_d = ST_RESP;
      err_d   = cur_err;
      rsel_d  = !cur_wr && !cur_err;
    end

    ram_we   = enter_resp && cur_wr && !cur_err;
    ram_addr = cur_addr[ADDR_WIDTH+1:2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      rsel_q  <= rsel_d;
    end
  end

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .be   (cur_be),
    .addr (ram_addr),
    .wdata(cur_wdata),
    .rdata(ram_rdata)
  );

  // RAM output is stable through RESP (same address, no write), so it is
  // gated rather than copied; the gate flop gives the zero reset value.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rsel_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with 2 wait states, one with 0,
// both checked against a word-array model of the memory.
module tb_dmem_responder;

  localparam int D0 = 0;  // WAIT_CYCLES=0 instance
  localparam int D2 = 1;  // WAIT_CYCLES=2 instance

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rv0 = 1'b0, rv2 = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_ready = 1'b0;
  logic        rr0, rr2, vld0, vld2, er0, er2;
  logic [31:0] rd0, rd2;

  int          sel = D2;
  logic        o_rr, o_vld, o_err;
  logic [31:0] o_rd;
  assign o_rr  = (sel == D0) ? rr0  : rr2;
  assign o_vld = (sel == D0) ? vld0 : vld2;
  assign o_err = (sel == D0) ? er0  : er2;
  assign o_rd  = (sel == D0) ? rd0  : rd2;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mdl   [2][256];
  bit          known [2][256];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(rr0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(vld0),
    .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(er0));

  dmem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(rr2), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(vld2),
    .resp_ready(resp_ready), .resp_rdata(rd2), .resp_err(er2));

  task automatic set_rv(input int s, input logic v);
    if (s == D0) rv0 = v; else rv2 = v;
  endtask

  // One complete transaction: handshake in, latency, response, optional stall, handshake out.
  task automatic txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input int hold, input bit poke);
    bit          exp_err, chk;
    logic [31:0] exp_rd, rd_seen;
    logic        err_seen;
    int          idx, t, lat, wcy;
    wcy     = (s == D0) ? 0 : 2;
    exp_err = (a[1:0] != 2'b00) || (a >= 32'h400);
    idx     = int'(a[9:2]);
    exp_rd  = (!w && !exp_err) ? mdl[s][idx] : 32'h0;
    chk     = w || exp_err || known[s][idx];
    if (w && !exp_err) begin
      for (int i = 0; i < 4; i++) if (be[i]) mdl[s][idx][8*i +: 8] = d[8*i +: 8];
      if (be == 4'hF) known[s][idx] = 1'b1;
    end
    sel = s;
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_be = be;
    set_rv(s, 1'b1);
    t = 0;
    while (!o_rr && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", a, o_rr);
      set_rv(s, 1'b0);
      return;
    end
    @(posedge clk); #1;
    set_rv(s, 1'b0);
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 1;
    while (!o_vld && lat < 50) begin @(posedge clk); #1; lat++; end
    nvec++;
    if (lat !== wcy + 1) begin
      nerr++; $display("FAIL latency addr=%h got %0d edges required %0d", a, lat, wcy + 1);
    end
    nvec++;
    if (o_err !== exp_err) begin
      nerr++; $display("FAIL resp_err addr=%h got %b required %b", a, o_err, exp_err);
    end
    if (chk) begin
      nvec++;
      if (o_rd !== exp_rd) begin
        nerr++; $display("FAIL resp_rdata addr=%h w=%b got %h required %h", a, w, o_rd, exp_rd);
      end
    end
    rd_seen = o_rd; err_seen = o_err;
    for (int k = 0; k < hold; k++) begin
      if (poke) begin
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h0; req_wdata = $urandom; req_be = 4'hF;
        set_rv(s, k[0]);
      end
      @(posedge clk); #1;
      nvec++;
      if (o_vld !== 1'b1 || o_rd !== rd_seen || o_err !== err_seen || o_rr !== 1'b0) begin
        nerr++;
        $display("FAIL stall_hold cyc=%0d got vld=%b rd=%h err=%b rdy=%b required 1 %h %b 0",
                 k, o_vld, o_rd, o_err, o_rr, rd_seen, err_seen);
      end
    end
    @(negedge clk);
    set_rv(s, 1'b0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    nvec++;
    if (o_vld !== 1'b0 || o_rd !== 32'h0 || o_err !== 1'b0 || o_rr !== 1'b1) begin
      nerr++;
      $display("FAIL resp_clear got vld=%b rd=%h err=%b rdy=%b required 0 0 0 1",
               o_vld, o_rd, o_err, o_rr);
    end
  endtask

  task automatic test_reset;
    #3;
    nvec++;
    if (rr0 !== 1'b1 || rr2 !== 1'b1 || vld0 !== 1'b0 || vld2 !== 1'b0 ||
        rd0 !== 32'h0 || rd2 !== 32'h0 || er0 !== 1'b0 || er2 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_values got rdy=%b%b vld=%b%b rd=%h/%h err=%b%b required 11 00 0/0 00",
               rr0, rr2, vld0, vld2, rd0, rd2, er0, er2);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_init;
    for (int i = 0; i < 256; i++) txn(D2, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0);
  endtask

  task automatic test_basic;
    txn(D2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    txn(D2, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    nvec++;
    if (mdl[D2][4] !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL basic_model got %h required deadbeef", mdl[D2][4]);
    end
  endtask

  task automatic test_byte_en;
    txn(D2, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0);
    txn(D2, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0);
    sel = D2;
    txn(D2, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);
    txn(D2, 1'b1, 32'h40, 32'h12345678, 4'h0, 1, 1'b0);
    txn(D2, 1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0);
  endtask

  task automatic test_errors;
    txn(D2, 1'b0, 32'h22, 32'h0, 4'hF, 0, 1'b0);
    txn(D2, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0, 1'b0);
    txn(D2, 1'b1, 32'h1, 32'hBADBAD00, 4'hF, 0, 1'b0);
    txn(D2, 1'b1, 32'h8000_0000, 32'h0BAD0BAD, 4'hF, 2, 1'b0);
    txn(D2, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    txn(D2, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1);
    txn(D2, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
  endtask

  task automatic test_reset_busy;
    txn(D2, 1'b1, 32'h30, 32'h0, 4'hF, 0, 1'b0);
    sel = D2;
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF; rv2 = 1'b1;
    @(posedge clk); #1;
    rv2 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    nvec++;
    if (rr2 !== 1'b1 || vld2 !== 1'b0 || rd2 !== 32'h0 || er2 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_busy got rdy=%b vld=%b rd=%h err=%b required 1 0 0 0", rr2, vld2, rd2, er2);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    txn(D2, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    int r;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
      else             a = {22'h0, 8'($urandom), 2'b00};
      txn(D2, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back;
    int  e, a1, a2;
    bit  acc;
    txn(D0, 1'b1, 32'h8, $urandom, 4'hF, 0, 1'b0);
    txn(D0, 1'b1, 32'hC, $urandom, 4'hF, 0, 1'b0);
    sel = D0;
    e = 0; a1 = -1; a2 = -1;
    @(negedge clk);
    resp_ready = 1'b1; req_write = 1'b0; req_addr = 32'h8; req_be = 4'h0; rv0 = 1'b1;
    while (a2 < 0 && e < 20) begin
      @(negedge clk);
      acc = rr0 && rv0;
      @(posedge clk); e++; #1;
      if (acc) begin
        nvec++;
        if (a1 < 0) begin
          a1 = e;
          if (vld0 !== 1'b1 || rd0 !== mdl[D0][2]) begin
            nerr++; $display("FAIL b2b_first got vld=%b rd=%h required 1 %h", vld0, rd0, mdl[D0][2]);
          end
          req_addr = 32'hC;
        end else begin
          a2 = e;
          rv0 = 1'b0;
          if (vld0 !== 1'b1 || rd0 !== mdl[D0][3]) begin
            nerr++; $display("FAIL b2b_second got vld=%b rd=%h required 1 %h", vld0, rd0, mdl[D0][3]);
          end
        end
      end
    end
    nvec++;
    if (a1 < 0 || a2 < 0 || a2 - a1 != 2) begin
      nerr++; $display("FAIL b2b_spacing got %0d required 2", a2 - a1);
    end
    rv0 = 1'b0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    nvec++;
    if (vld0 !== 1'b0 || rr0 !== 1'b1) begin
      nerr++; $display("FAIL b2b_idle got vld=%b rdy=%b required 0 1", vld0, rr0);
    end
  endtask

  initial begin
    test_reset;
    test_init;
    test_basic;
    test_byte_en;
    test_errors;
    test_backpressure;
    test_reset_busy;
    test_random;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the multi-cycle CPU: the target side of the CPU's load/store request interface.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then performs a byte-enabled write or a word read.
- Returns the result through a valid/ready response channel, replacing the CPU's zero-latency DMEM with a realistic slave.

Parameters:
- ADDR_WIDTH, 8, word-address bits; the array holds 2**ADDR_WIDTH 32-bit words.
- DATA_WIDTH, 32, data word width; fixed at 32, byte lanes = DATA_WIDTH/8.
- WAIT_CYCLES, 2, wait states between request accept and response; 0 is legal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  initiator has a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i selects bits [8i+7:8i].
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator takes the response.
- resp_rdata  out  32  load data; 0 for stores and for errors.
- resp_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset: asynchronous and active-high; it is the only asynchronous input.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
- Array contents are not affected by reset.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - Accept occurs on a rising edge with req_valid && req_ready.
  - At accept, latch req_write, req_addr, req_wdata and req_be.
  - Next state: BUSY with counter = WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise directly RESP.
- BUSY:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter==0, next state is RESP.
- Entering RESP (a single edge):
  - Error check: err = (latched addr[1:0] != 0) || (latched addr[31:ADDR_WIDTH+2] != 0).
  - Store, no error: write the enabled bytes of word addr[ADDR_WIDTH+1:2]; resp_rdata=0.
  - Load, no error: resp_rdata = the full word (req_be ignored).
  - Error: no array write; resp_rdata=0; resp_err=1.
  - A store with req_be=0 completes normally with no change to the array.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until the handshake.
  - On resp_valid && resp_ready: next state is IDLE; resp_valid, resp_rdata and resp_err clear to 0.
- Latency: resp_valid rises exactly WAIT_CYCLES+1 rising edges after the accept edge.
  - WAIT_CYCLES=0: resp_valid is high in the cycle immediately following the accept edge.
- Throughput:
  - Strictly one outstanding request.
  - req_ready rises in the cycle after the response handshake; no same-cycle turnaround.
  - Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- req_valid while req_ready=0 is ignored and has no side effects.
- Request inputs may change freely after the accept edge.
- Reset mid-operation:
  - In BUSY, the pending store is discarded and the array is unchanged.
  - In RESP, the pending response is dropped.
  - Either way, return to IDLE immediately.
- Read-after-write: a load accepted after a store's response handshake returns the stored data.

Decomposition:
- Shared package cpu_mem_pkg:
  - state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - BYTE_LANES constant;
  - the error-check function.
- One sub-module, dmem_array: synchronous byte-enabled single-port RAM.
  - Ports: clk, we, be[3:0], addr[ADDR_WIDTH-1:0], wdata, rdata.
  - Registered read; no reset.
- dmem_responder owns the FSM, the wait counter, the request latch and the response register.

Test Plan:
- Basic store/load, WAIT_CYCLES=2:
  - Store addr=0x10, wdata=0xDEADBEEF, be=4'hF, then load addr=0x10.
  - Required: resp_valid 3 edges after each accept; load resp_rdata=0xDEADBEEF, resp_err=0.
- Byte enables:
  - Store 0x11223344 to 0x20, then store 0xAABBCCDD with be=4'b0101, then load 0x20.
  - Required: resp_rdata=0x11BB33DD.
- Errors:
  - Load addr=0x22 gives resp_err=1, rdata=0.
  - Store to addr=0x400 (ADDR_WIDTH=8) gives resp_err=1.
  - Required: a following load of 0x0 returns its prior contents unchanged.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles during a load of 0x10.
  - Required: resp_valid, resp_rdata and resp_err stay stable; req_ready=0 throughout; a req_valid pulse during this time is ignored.
- Reset mid-BUSY:
  - Pre-load 0x30=0x0; assert reset one cycle after accepting a store of 0x55 to 0x30.
  - Required: all outputs return to reset values asynchronously; a subsequent load of 0x30 returns 0x0.
- WAIT_CYCLES=0 back-to-back:
  - Two loads with resp_ready tied 1.
  - Required: resp_valid in the cycle after each accept; second accept occurs 2 cycles after the first.
